// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a registered single-cycle path (add, sub, shifts, logic, compares)
// and a one-bit-per-cycle iterative path (shift-add multiply, optional restoring divide).
//
// Parameters:
//   WIDTH - operand/result width (8..64, even)
//   CNT_W - iteration counter width
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   in_valid_i/in_ready_o - request handshake; op_i, a_i, b_i latched on acceptance
//   kill_i                - flush, abandons any in-flight operation
//   out_valid_o/out_ready_i, result_o - result handshake; result_o is 0 when not valid
//   busy_o                - high whenever the unit is not idle
//
// Build option: define ALU_SEQ_DIV_EN to include the divider (ops 12-15). Without it those
// ops complete in one cycle with a zero result.

module alu_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             kill_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             busy_o
);

  localparam int unsigned ShW = $clog2(WIDTH);

  localparam logic [3:0] OpAdd   = 4'd0;
  localparam logic [3:0] OpSub   = 4'd1;
  localparam logic [3:0] OpSll   = 4'd2;
  localparam logic [3:0] OpSrl   = 4'd3;
  localparam logic [3:0] OpSra   = 4'd4;
  localparam logic [3:0] OpXor   = 4'd5;
  localparam logic [3:0] OpOr    = 4'd6;
  localparam logic [3:0] OpAnd   = 4'd7;
  localparam logic [3:0] OpSlt   = 4'd8;
  localparam logic [3:0] OpSltu  = 4'd9;
  localparam logic [3:0] OpMul   = 4'd10;
  localparam logic [3:0] OpMulhu = 4'd11;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] hi_q, hi_d;   // product high half / partial remainder
  logic [WIDTH-1:0] lo_q, lo_d;   // multiplier bits / dividend-then-quotient bits
  logic [WIDTH-1:0] res_q, res_d;

  logic             accept;
  logic             multi_op;
  logic             last_iter;
  logic [ShW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] step_hi, step_lo, calc_res;

`ifdef ALU_SEQ_DIV_EN
  logic [WIDTH-1:0] b_q, b_d;
  logic             div_signed;
  logic [WIDTH-1:0] div_dvsr;
  logic [WIDTH:0]   div_shift, div_diff;
  logic [WIDTH-1:0] div_hi, div_lo, div_quo, div_rem;

  assign multi_op = op_i[3] & (op_i[2] | op_i[1]);  // ops 10..15
`else
  assign multi_op = (op_i == OpMul) || (op_i == OpMulhu);
`endif

  assign accept    = in_valid_i && (state_q == StIdle) && !kill_i;
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
  assign shamt     = b_i[ShW-1:0];

  // Single-cycle results; iterative ops (and disabled divide ops) yield 0 here.
  always_comb begin
    alu_res = '0;
    case (op_i)
      OpAdd:   alu_res = a_i + b_i;
      OpSub:   alu_res = a_i - b_i;
      OpSll:   alu_res = a_i << shamt;
      OpSrl:   alu_res = a_i >> shamt;
      OpSra:   alu_res = $signed(a_i) >>> shamt;
      OpXor:   alu_res = a_i ^ b_i;
      OpOr:    alu_res = a_i | b_i;
      OpAnd:   alu_res = a_i & b_i;
      OpSlt:   alu_res = WIDTH'($signed(a_i) < $signed(b_i));
      OpSltu:  alu_res = WIDTH'(a_i < b_i);
      default: alu_res = '0;
    endcase
  end

  // One iteration of the multi-cycle datapath, plus the result it would finish with.
  always_comb begin
    // Shift-add: {hi, lo} shifts right, adding the multiplicand when the multiplier LSB is set.
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    step_hi  = mul_sum[WIDTH:1];
    step_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
    calc_res = (op_q == OpMul) ? step_lo : step_hi;
`ifdef ALU_SEQ_DIV_EN
    // Restoring divide on magnitudes; signs are reapplied on the final iteration.
    div_signed = ~op_q[0];
    div_dvsr   = (div_signed && b_q[WIDTH-1]) ? -b_q : b_q;
    div_shift  = {hi_q, lo_q[WIDTH-1]};
    div_diff   = div_shift - {1'b0, div_dvsr};
    div_hi     = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
    div_lo     = {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
    div_quo    = (div_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -div_lo : div_lo;
    div_rem    = (div_signed && a_q[WIDTH-1]) ? -div_hi : div_hi;
    if (b_q == '0) begin
      div_quo = '1;
      div_rem = a_q;
    end
    if (op_q[3:2] == 2'b11) begin
      step_hi  = div_hi;
      step_lo  = div_lo;
      calc_res = op_q[1] ? div_rem : div_quo;
    end
`endif
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = multi_op ? StCalc : StDone;
      StCalc:  if (last_iter) state_d = StDone;
      StDone:  if (out_ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (kill_i) state_d = StIdle;
  end

  // Datapath next-state.
  always_comb begin
    op_d  = op_q;
    a_d   = a_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    res_d = res_q;
    cnt_d = '0;
`ifdef ALU_SEQ_DIV_EN
    b_d   = b_q;
`endif
    if (kill_i) begin
      res_d = '0;
    end else if (accept) begin
      op_d  = op_i;
      a_d   = a_i;
      hi_d  = '0;
      lo_d  = b_i;
      res_d = alu_res;
`ifdef ALU_SEQ_DIV_EN
      b_d = b_i;
      if (op_i[3:2] == 2'b11) lo_d = (!op_i[0] && a_i[WIDTH-1]) ? -a_i : a_i;
`endif
    end else if (state_q == StCalc) begin
      hi_d = step_hi;
      lo_d = step_lo;
      if (last_iter) res_d = calc_res;
      else           cnt_d = cnt_q + 1'b1;
    end else if ((state_q == StDone) && out_ready_i) begin
      res_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
`ifdef ALU_SEQ_DIV_EN
      b_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
`ifdef ALU_SEQ_DIV_EN
      b_q     <= b_d;
`endif
    end
  end

  // Outputs.
  always_comb begin
    in_ready_o  = (state_q == StIdle);
    busy_o      = (state_q != StIdle);
    out_valid_o = (state_q == StDone);
    result_o    = out_valid_o ? res_q : '0;
  end

endmodule
